vcore_cfg_master: RTL and testbench

VCORE_CFG_MASTER -- requirements
Module: vcore_cfg_master

---
 rtl/vcore_cfg_master.sv | 139 +++++++++++++
 tb/tb_vcore_cfg_master.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vcore_cfg_master.sv
// Configuration write master: queues register writes in a small FIFO and issues
// them as Avalon-MM writes, optionally holding a command until a frame boundary.
module vcore_cfg_master #(
  parameter int AVM_AW     = 4,
  parameter int AVM_DW     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_sync,
  input  logic [AVM_AW-1:0] cmd_address,
  input  logic [AVM_DW-1:0] cmd_writedata,
  input  logic              frame_start,
  output logic              avm_write,
  output logic [AVM_AW-1:0] avm_address,
  output logic [AVM_DW-1:0] avm_writedata,
  input  logic              avm_waitrequest,
  output logic              busy,
  output logic [15:0]       wr_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 1 + AVM_AW + AVM_DW;

  typedef enum logic [1:0] {IDLE, WAIT_FRAME, WRITE} state_t;

  state_t            state_q, state_d;
  logic [EW-1:0]     mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              avm_write_q, avm_write_d;
  logic [AVM_AW-1:0] avm_address_q, avm_address_d;
  logic [AVM_DW-1:0] avm_writedata_q, avm_writedata_d;
  logic [15:0]       wr_count_q, wr_count_d;

  logic              push, pop, empty;
  logic [EW-1:0]     head;
  logic              head_sync;
  logic [AVM_AW-1:0] head_addr;
  logic [AVM_DW-1:0] head_data;

  assign head      = mem_q[rd_ptr_q];
  assign head_sync = head[EW-1];
  assign head_addr = head[AVM_DW +: AVM_AW];
  assign head_data = head[AVM_DW-1:0];
  assign empty     = (count_q == '0);

  // FIFO bookkeeping; ready is derived from next occupancy so it never sees a same-cycle pop
  always_comb begin
    push     = cmd_valid & cmd_ready_q;
    pop      = (state_q == WRITE) & ~avm_waitrequest;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    cmd_ready_d = (count_d != CW'(FIFO_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_sync, cmd_address, cmd_writedata};
  end

  always_comb begin
    state_d         = state_q;
    avm_address_d   = avm_address_q;
    avm_writedata_d = avm_writedata_q;
    wr_count_d      = wr_count_q;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          if (head_sync) begin
            state_d = WAIT_FRAME;
          end else begin
            state_d         = WRITE;
            avm_address_d   = head_addr;
            avm_writedata_d = head_data;
          end
        end
      end
      WAIT_FRAME: begin
        if (frame_start) begin
          state_d         = WRITE;
          avm_address_d   = head_addr;
          avm_writedata_d = head_data;
        end
      end
      WRITE: begin
        if (!avm_waitrequest) begin
          state_d    = IDLE;
          wr_count_d = wr_count_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    avm_write_d = (state_d == WRITE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      cmd_ready_q     <= 1'b1;
      avm_write_q     <= 1'b0;
      avm_address_q   <= '0;
      avm_writedata_q <= '0;
      wr_count_q      <= '0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      cmd_ready_q     <= cmd_ready_d;
      avm_write_q     <= avm_write_d;
      avm_address_q   <= avm_address_d;
      avm_writedata_q <= avm_writedata_d;
      wr_count_q      <= wr_count_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign avm_write     = avm_write_q;
  assign avm_address   = avm_address_q;
  assign avm_writedata = avm_writedata_q;
  assign wr_count      = wr_count_q;
  assign busy          = ~empty | (state_q != IDLE);

endmodule

// File: tb/tb_vcore_cfg_master.sv
// Scoreboard bench for vcore_cfg_master: expected writes are queued at accept
// time and compared when the Avalon write completes.
module tb_vcore_cfg_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_sync;
  logic [3:0]  cmd_address;
  logic [31:0] cmd_writedata;
  logic        frame_start;
  logic        avm_write;
  logic [3:0]  avm_address;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;
  logic        busy;
  logic [15:0] wr_count;

  vcore_cfg_master #(.AVM_AW(4), .AVM_DW(32), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sync(cmd_sync),
    .cmd_address(cmd_address), .cmd_writedata(cmd_writedata),
    .frame_start(frame_start),
    .avm_write(avm_write), .avm_address(avm_address), .avm_writedata(avm_writedata),
    .avm_waitrequest(avm_waitrequest),
    .busy(busy), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  logic [35:0] sbq[$];
  logic [15:0] exp_cnt = 16'd0;
  int          wlen = 0;
  int          last_wlen = 0;
  logic        saw_write = 1'b0;
  logic [3:0]  prev_addr;
  logic [31:0] prev_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic s, input logic [3:0] a, input logic [31:0] d, output int waits);
    cmd_valid     = 1'b1;
    cmd_sync      = s;
    cmd_address   = a;
    cmd_writedata = d;
    waits = 0;
    while (!cmd_ready && waits < 200) begin
      step(1);
      waits++;
    end
    if (!cmd_ready) begin
      chk("push_timeout", 64'd0, 64'd1);
    end else begin
      sbq.push_back({a, d});
      step(1);
    end
  endtask

  task automatic drain();
    int g = 0;
    while ((busy || sbq.size() != 0) && g < 300) begin
      step(1);
      g++;
    end
    chk("drain_busy", busy, 0);
    chk("drain_sbq", sbq.size(), 0);
  endtask

  task automatic wait_write();
    int g = 0;
    while (!avm_write && g < 100) begin
      step(1);
      g++;
    end
    chk("wait_write", avm_write, 1);
  endtask

  // Monitor: samples on the falling edge, between stimulus updates and active edges
  always @(negedge clk) begin
    if (rst && avm_write) begin
      saw_write = 1'b1;
      wlen++;
      if (wlen > 1) begin
        chk("stable_addr", avm_address, prev_addr);
        chk("stable_data", avm_writedata, prev_data);
      end
      prev_addr = avm_address;
      prev_data = avm_writedata;
      if (!avm_waitrequest) begin
        if (sbq.size() == 0) begin
          chk("spurious_write", 64'd1, 64'd0);
        end else begin
          logic [35:0] e;
          e = sbq.pop_front();
          chk("wr_addr", avm_address, e[35:32]);
          chk("wr_data", avm_writedata, e[31:0]);
          chk("wr_count_pre", wr_count, exp_cnt);
          exp_cnt = exp_cnt + 16'd1;
        end
        last_wlen = wlen;
        wlen = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int w;
    rst = 1'b0;
    cmd_valid = 1'b0;
    cmd_sync = 1'b0;
    cmd_address = '0;
    cmd_writedata = '0;
    frame_start = 1'b0;
    avm_waitrequest = 1'b0;
    step(3);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_write", avm_write, 0);
    chk("rst_addr", avm_address, 0);
    chk("rst_data", avm_writedata, 0);
    chk("rst_count", wr_count, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;

    // Single unsynced write, latency and pulse width
    push(1'b0, 4'h0, 32'h1, w);
    cmd_valid = 1'b0;
    chk("single_w0", avm_write, 0);
    step(1);
    chk("single_w1", avm_write, 1);
    step(1);
    chk("single_w2", avm_write, 0);
    chk("single_cnt", wr_count, 1);

    // Stalled write
    avm_waitrequest = 1'b1;
    push(1'b0, 4'h2, 32'hA5, w);
    cmd_valid = 1'b0;
    wait_write();
    step(5);
    chk("stall_still_high", avm_write, 1);
    avm_waitrequest = 1'b0;
    step(1);
    chk("stall_len", last_wlen, 6);
    chk("stall_cnt", wr_count, 2);

    // Frame sync: pulse on the IDLE->WAIT_FRAME edge is ignored
    push(1'b1, 4'h3, 32'h3333_0003, w);
    frame_start = 1'b1;
    push(1'b0, 4'h4, 32'h4444_0004, w);
    frame_start = 1'b0;
    cmd_valid = 1'b0;
    saw_write = 1'b0;
    step(20);
    chk("sync_hold_write", saw_write, 0);
    chk("sync_hold_busy", busy, 1);
    frame_start = 1'b1;
    step(1);
    frame_start = 1'b0;
    drain();
    chk("sync_cnt", wr_count, 4);

    // Full FIFO and back-pressure
    avm_waitrequest = 1'b1;
    push(1'b0, 4'h5, 32'h5, w);
    push(1'b0, 4'h6, 32'h6, w);
    push(1'b0, 4'h7, 32'h7, w);
    push(1'b0, 4'h8, 32'h8, w);
    chk("full_ready", cmd_ready, 0);
    cmd_address = 4'h9;
    cmd_writedata = 32'h9;
    step(3);
    chk("full_hold_ready", cmd_ready, 0);
    chk("full_sbq", sbq.size(), 4);
    avm_waitrequest = 1'b0;
    push(1'b0, 4'h9, 32'h9, w);
    cmd_valid = 1'b0;
    drain();
    chk("full_cnt", wr_count, 9);

    // Counter wrap
    force dut.wr_count_q = 16'hFFFF;
    step(1);
    release dut.wr_count_q;
    exp_cnt = 16'hFFFF;
    step(1);
    chk("wrap_preload", wr_count, 16'hFFFF);
    push(1'b0, 4'hF, 32'hDEAD_BEEF, w);
    cmd_valid = 1'b0;
    drain();
    chk("wrap_cnt", wr_count, 0);

    // Reset during a stalled write with three commands queued
    avm_waitrequest = 1'b1;
    push(1'b0, 4'hA, 32'hA, w);
    push(1'b0, 4'hB, 32'hB, w);
    push(1'b0, 4'hC, 32'hC, w);
    push(1'b0, 4'hD, 32'hD, w);
    cmd_valid = 1'b0;
    wait_write();
    #1;
    rst = 1'b0;
    #1;
    chk("rst_mid_write", avm_write, 0);
    chk("rst_mid_ready", cmd_ready, 1);
    sbq.delete();
    exp_cnt = 16'd0;
    wlen = 0;
    step(2);
    rst = 1'b1;
    avm_waitrequest = 1'b0;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_cnt", wr_count, 0);
    saw_write = 1'b0;
    step(10);
    chk("post_rst_nowrite", saw_write, 0);
    chk("post_rst_cnt2", wr_count, 0);

    // First accept right after reset release
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    push(1'b0, 4'h1, 32'h1234_5678, w);
    cmd_valid = 1'b0;
    chk("first_accept_waits", w, 0);
    drain();
    chk("final_cnt", wr_count, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
